als_spi_master: RTL

SPI initiator for the PMOD ALS light sensor (ADC081S021-style, read-only 16-bit frame). It generates a free-running SCK and CS framing, and samples SDO. From each frame it extracts the 8-bit light value and flags framing errors. It sits in mfp_system under MFP_DEMO_LIGHT_SENSOR as the counterpart to the sensor (or the bench sensor stub), and feeds an AHB-readable register.

---
 rtl/als_spi_master.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/als_spi_master.sv
// SPI initiator for the PMOD ALS sensor: free-running SCK, CS framing of 16-bit
// read-only frames, extraction of the 8-bit light value plus a framing-error flag.
module als_spi_master #(
    parameter int DIV     = 8,
    parameter int GAP_SCK = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        auto_en,
    output logic        busy,
    output logic        cs,
    output logic        sck,
    input  logic        sdo,
    output logic [15:0] raw,
    output logic [7:0]  value,
    output logic        err,
    output logic        valid
);
    localparam logic [7:0] DIV_M1 = 8'(DIV - 1);
    localparam logic [3:0] GAP_M1 = 4'(GAP_SCK - 1);

    typedef enum logic [1:0] {IDLE, ARM, SHIFT, GAP} state_t;

    state_t      state_q, state_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic        sck_q, sck_d;
    logic        cs_q, cs_d;
    logic        busy_q, busy_d;
    logic        pend_q, pend_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [15:0] shreg_q, shreg_d;
    logic        load_q, load_d;
    logic [15:0] raw_q, raw_d;
    logic [7:0]  value_q, value_d;
    logic        err_q, err_d;
    logic        valid_q, valid_d;
    logic        wrap, rise;

    always_comb begin
        wrap      = (div_cnt_q == DIV_M1);
        rise      = wrap & ~sck_q;
        div_cnt_d = wrap ? 8'd0 : div_cnt_q + 8'd1;
        sck_d     = wrap ? ~sck_q : sck_q;

        state_d   = state_q;
        cs_d      = cs_q;
        busy_d    = busy_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        shreg_d   = shreg_q;
        load_d    = 1'b0;
        // Only one extra request is remembered while a frame is in flight.
        pend_d    = pend_q | (start & (state_q != IDLE));

        valid_d   = load_q;
        raw_d     = raw_q;
        value_d   = value_q;
        err_d     = err_q;
        if (load_q) begin
            raw_d   = shreg_q;
            value_d = shreg_q[11:4];
            err_d   = (shreg_q[15:12] != 4'd0) | (shreg_q[3:0] != 4'd0);
        end

        case (state_q)
            IDLE: begin
                if (start | auto_en | pend_q) begin
                    state_d = ARM;
                    busy_d  = 1'b1;
                    pend_d  = 1'b0;
                end
            end
            ARM: begin
                if (rise) begin
                    cs_d      = 1'b0;
                    bit_cnt_d = 4'd0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (rise) begin
                    shreg_d   = {shreg_q[14:0], sdo};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd15) begin
                        cs_d      = 1'b1;
                        load_d    = 1'b1;
                        gap_cnt_d = 4'd0;
                        state_d   = GAP;
                    end
                end
            end
            GAP: begin
                if (rise) begin
                    if (gap_cnt_q == GAP_M1) begin
                        // A follow-on frame reuses this rise as its arming edge,
                        // so CS stays high for exactly GAP_SCK SCK periods.
                        if (auto_en | pend_q) begin
                            pend_d    = 1'b0;
                            cs_d      = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = SHIFT;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_cnt_q <= 8'd0;
            sck_q     <= 1'b0;
            cs_q      <= 1'b1;
            busy_q    <= 1'b0;
            pend_q    <= 1'b0;
            bit_cnt_q <= 4'd0;
            gap_cnt_q <= 4'd0;
            shreg_q   <= 16'd0;
            load_q    <= 1'b0;
            raw_q     <= 16'd0;
            value_q   <= 8'd0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            sck_q     <= sck_d;
            cs_q      <= cs_d;
            busy_q    <= busy_d;
            pend_q    <= pend_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            shreg_q   <= shreg_d;
            load_q    <= load_d;
            raw_q     <= raw_d;
            value_q   <= value_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
        end
    end

    assign busy  = busy_q;
    assign cs    = cs_q;
    assign sck   = sck_q;
    assign raw   = raw_q;
    assign value = value_q;
    assign err   = err_q;
    assign valid = valid_q;
endmodule
